player_motion: RTL and testbench

PLAYER_MOTION -- requirements
Module: player_motion

---
 rtl/player_motion.sv | 153 +++++++++++++++
 tb/tb_player_motion.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// ============================================================================
// Module   : player_motion
// Purpose  : Sub-cell player stepper with wall/grid checking on a 10x15 maze.
//            Optional macro PLAYER_MOTION_REVERSE_EN allows mid-cell reversal.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module player_motion (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         button_1,
  input  logic         button_2,
  input  logic [159:0] h_walls,
  input  logic [164:0] v_walls,
  output logic [8:0]   pos_x,
  output logic [8:0]   pos_y,
  output logic [1:0]   direction,
  output logic         busy,
  output logic         done,
  output logic         blocked,
  output logic         cell_entered
);

  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_PY = 2'd1;
  localparam logic [1:0] DIR_NX = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_MOVE  = 2'd2
  } state_t;

  state_t     r_state, w_state_next;
  logic [1:0] r_sync1, r_sync2;
  logic [1:0] r_dir_sel;
  logic [1:0] w_sel_dir;
  logic       w_aligned;
  logic       w_hit;
  logic [3:0] w_cx, w_cy, w_wall_col, w_wall_row;
  logic [7:0] w_v_idx, w_h_idx;
  logic [8:0] w_next_x, w_next_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {button_1, button_2};
      r_sync2 <= r_sync1;
    end
  end

  assign w_aligned = (pos_x[4:0] == 5'd0) && (pos_y[4:0] == 5'd0);
  assign w_cx      = pos_x[8:5];
  assign w_cy      = pos_y[8:5];

  always_comb begin
    w_sel_dir = direction;
    if (w_aligned) begin
      w_sel_dir = r_sync2;
    end
`ifdef PLAYER_MOTION_REVERSE_EN
    else if (r_sync2 == (direction ^ 2'b10)) begin
      w_sel_dir = r_sync2;
    end
`endif
  end

  // The wall crossed is the one on the near edge of the destination cell.
  assign w_wall_col = (w_sel_dir == DIR_PX) ? (w_cx + 4'd1) : w_cx;
  assign w_wall_row = (w_sel_dir == DIR_PY) ? (w_cy + 4'd1) : w_cy;
  assign w_v_idx    = 8'd164 - 8'd11 * {4'd0, w_cy} - {4'd0, w_wall_col};
  assign w_h_idx    = 8'd159 - 8'd10 * {4'd0, w_wall_row} - {4'd0, w_cx};

  always_comb begin
    w_hit = 1'b0;
    case (w_sel_dir)
      DIR_PX:  w_hit = (w_cx == 4'd9)  || v_walls[w_v_idx];
      DIR_NX:  w_hit = (w_cx == 4'd0)  || v_walls[w_v_idx];
      DIR_PY:  w_hit = (w_cy == 4'd14) || h_walls[w_h_idx];
      default: w_hit = (w_cy == 4'd0)  || h_walls[w_h_idx];
    endcase
  end

  always_comb begin
    w_next_x = pos_x;
    w_next_y = pos_y;
    case (r_dir_sel)
      DIR_PX:  w_next_x = pos_x + 9'd1;
      DIR_NX:  w_next_x = pos_x - 9'd1;
      DIR_PY:  w_next_y = pos_y + 9'd1;
      default: w_next_y = pos_y - 9'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (step) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = ST_MOVE;
      ST_MOVE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x        <= 9'd0;
      pos_y        <= 9'd0;
      direction    <= DIR_PX;
      r_dir_sel    <= DIR_PX;
      blocked      <= 1'b0;
      done         <= 1'b0;
      cell_entered <= 1'b0;
    end else begin
      done         <= 1'b0;
      cell_entered <= 1'b0;
      case (r_state)
        ST_CHECK: begin
          r_dir_sel <= w_sel_dir;
          blocked   <= w_aligned && w_hit;
        end
        ST_MOVE: begin
          done <= 1'b1;
          if (!blocked) begin
            direction    <= r_dir_sel;
            pos_x        <= w_next_x;
            pos_y        <= w_next_y;
            cell_entered <= (w_next_x[4:0] == 5'd0) && (w_next_y[4:0] == 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_player_motion.sv
// ============================================================================
// Module   : tb_player_motion
// Purpose  : Self-checking scoreboard bench for player_motion.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_player_motion;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         step = 1'b0;
  logic         button_1 = 1'b0;
  logic         button_2 = 1'b0;
  logic [159:0] h_walls = '0;
  logic [164:0] v_walls = '0;
  logic [8:0]   pos_x, pos_y;
  logic [1:0]   direction;
  logic         busy, done, blocked, cell_entered;

  typedef struct packed {
    logic [8:0] px;
    logic [8:0] py;
    logic [1:0] dir;
    logic       blk;
    logic       ce;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  player_motion dut (
    .clk(clk), .rst(rst), .step(step), .button_1(button_1), .button_2(button_2),
    .h_walls(h_walls), .v_walls(v_walls), .pos_x(pos_x), .pos_y(pos_y),
    .direction(direction), .busy(busy), .done(done), .blocked(blocked),
    .cell_entered(cell_entered)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b0; step = 1'b0; button_1 = 1'b0; button_2 = 1'b0;
    h_walls = '0; v_walls = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic set_buttons(input logic b1, input logic b2);
    @(negedge clk);
    button_1 = b1; button_2 = b2;
    repeat (4) @(posedge clk);
  endtask

  // Pulses step for one sampling edge, then waits (bounded) for done.
  // lat counts rising edges after the sampling edge until done is seen.
  task automatic issue_step(input bit release_rst, output bit got, output int lat);
    @(negedge clk);
    if (release_rst) rst = 1'b1;
    step = 1'b1;
    @(posedge clk);
    @(negedge clk) step = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin got = 1'b1; break; end
    end
  endtask

  task automatic run_steps(input int n);
    bit got; int lat;
    for (int i = 0; i < n; i++) issue_step(1'b0, got, lat);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++;
    if ({pos_x, pos_y, direction, busy, done, blocked, cell_entered} !== 24'd0) begin
      n_err++;
      $display("FAIL reset_state: got px=%0d py=%0d dir=%0d busy=%b done=%b blk=%b ce=%b, want all 0",
               pos_x, pos_y, direction, busy, done, blocked, cell_entered);
    end
  endtask

  task automatic test_basic();
    bit got; int lat;
    apply_reset();
    sb.push_back('{px: 9'd1, py: 9'd0, dir: 2'd0, blk: 1'b0, ce: 1'b0});
    issue_step(1'b0, got, lat);
    // done is registered on the second edge after sampling: the third cycle.
    n_cmp++;
    if (!got || lat != 2) begin
      n_err++; $display("FAIL basic_latency: got done=%b after %0d edges, want done after 2", got, lat);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL basic_move: got px=%0d py=%0d dir=%0d blk=%b ce=%b, want px=%0d py=%0d dir=%0d blk=%b ce=%b",
                        pos_x, pos_y, direction, blocked, cell_entered, e.px, e.py, e.dir, e.blk, e.ce);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse_width: got done=%b, want 0", done);
    end
  endtask

  task automatic test_blocked();
    bit got; int lat;
    apply_reset();
    set_buttons(1'b1, 1'b1);
    sb.push_back('{px: 9'd0, py: 9'd0, dir: 2'd0, blk: 1'b1, ce: 1'b0});
    issue_step(1'b0, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL blocked_neg_y: got done=%b px=%0d py=%0d dir=%0d blk=%b, want done=1 px=0 py=0 dir=0 blk=1",
                        got, pos_x, pos_y, direction, blocked);
    end
    repeat (5) @(posedge clk); #1;
    n_cmp++;
    if (blocked !== 1'b1) begin
      n_err++; $display("FAIL blocked_hold: got blk=%b, want 1", blocked);
    end
    set_buttons(1'b1, 1'b0);
    sb.push_back('{px: 9'd0, py: 9'd0, dir: 2'd0, blk: 1'b1, ce: 1'b0});
    issue_step(1'b0, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL blocked_neg_x: got done=%b px=%0d dir=%0d blk=%b, want done=1 px=0 dir=0 blk=1",
                        got, pos_x, direction, blocked);
    end
    set_buttons(1'b0, 1'b1);
    h_walls[149] = 1'b1;
    sb.push_back('{px: 9'd0, py: 9'd0, dir: 2'd0, blk: 1'b1, ce: 1'b0});
    issue_step(1'b0, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL blocked_h_wall: got done=%b py=%0d dir=%0d blk=%b, want done=1 py=0 dir=0 blk=1",
                        got, pos_y, direction, blocked);
    end
    h_walls[149] = 1'b0;
    sb.push_back('{px: 9'd0, py: 9'd1, dir: 2'd1, blk: 1'b0, ce: 1'b0});
    issue_step(1'b0, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL open_pos_y: got done=%b py=%0d dir=%0d blk=%b, want done=1 py=1 dir=1 blk=0",
                        got, pos_y, direction, blocked);
    end
  endtask

  task automatic test_cell_walk();
    bit got; int lat; int ce_seen;
    apply_reset();
    ce_seen = 0;
    for (int i = 1; i <= 32; i++) begin
      sb.push_back('{px: 9'(i), py: 9'd0, dir: 2'd0, blk: 1'b0, ce: (i == 32)});
      issue_step(1'b0, got, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
        n_err++; $display("FAIL walk_step_%0d: got done=%b px=%0d ce=%b, want done=1 px=%0d ce=%b",
                          i, got, pos_x, cell_entered, e.px, e.ce);
      end
      if (cell_entered) ce_seen++;
    end
    n_cmp++;
    if (ce_seen != 1) begin
      n_err++; $display("FAIL walk_cell_entered_count: got %0d, want 1", ce_seen);
    end
  endtask

  task automatic test_wall();
    bit got; int lat;
    apply_reset();
    run_steps(64);
    set_buttons(1'b0, 1'b1);
    run_steps(96);
    set_buttons(1'b0, 1'b0);
    v_walls[128] = 1'b1;
    sb.push_back('{px: 9'd64, py: 9'd96, dir: 2'd1, blk: 1'b1, ce: 1'b0});
    issue_step(1'b0, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL wall_blocked: got done=%b px=%0d py=%0d dir=%0d blk=%b, want done=1 px=64 py=96 dir=1 blk=1",
                        got, pos_x, pos_y, direction, blocked);
    end
    v_walls[128] = 1'b0;
    sb.push_back('{px: 9'd65, py: 9'd96, dir: 2'd0, blk: 1'b0, ce: 1'b0});
    issue_step(1'b0, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL wall_cleared: got done=%b px=%0d py=%0d dir=%0d blk=%b, want done=1 px=65 py=96 dir=0 blk=0",
                        got, pos_x, pos_y, direction, blocked);
    end
  endtask

  task automatic test_reverse();
    bit got; int lat;
    apply_reset();
    run_steps(5);
    set_buttons(1'b1, 1'b0);
`ifdef PLAYER_MOTION_REVERSE_EN
    sb.push_back('{px: 9'd4, py: 9'd0, dir: 2'd2, blk: 1'b0, ce: 1'b0});
`else
    sb.push_back('{px: 9'd6, py: 9'd0, dir: 2'd0, blk: 1'b0, ce: 1'b0});
`endif
    issue_step(1'b0, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL mid_cell_reverse: got done=%b px=%0d dir=%0d blk=%b, want done=1 px=%0d dir=%0d blk=0",
                        got, pos_x, direction, blocked, e.px, e.dir);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    apply_reset();
    sb.push_back('{px: 9'd1, py: 9'd0, dir: 2'd0, blk: 1'b0, ce: 1'b0});
    @(negedge clk) step = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_in_move: got busy=%b, want 1", busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL b2b_done: got done=%b, want 1", done);
    end
    @(negedge clk) step = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++; $display("FAIL step_while_busy: got %0d extra done pulses, want 0", extra);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL b2b_position: got px=%0d py=%0d, want px=1 py=0", pos_x, pos_y);
    end
  endtask

  task automatic test_reset_abort();
    bit got; int lat; int seen;
    apply_reset();
    run_steps(1);
    @(negedge clk) step = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_in_check: got busy=%b, want 1", busy);
    end
    step = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({pos_x, pos_y, direction, busy, done, blocked, cell_entered} !== 24'd0) begin
      n_err++; $display("FAIL abort_outputs: got px=%0d py=%0d dir=%0d busy=%b done=%b blk=%b ce=%b, want all 0",
                        pos_x, pos_y, direction, busy, done, blocked, cell_entered);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || pos_x != 9'd0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d cycles with done/move, want 0", seen);
    end
    sb.push_back('{px: 9'd1, py: 9'd0, dir: 2'd0, blk: 1'b0, ce: 1'b0});
    issue_step(1'b1, got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat != 2 || {pos_x, pos_y, direction, blocked, cell_entered} !== e) begin
      n_err++; $display("FAIL step_after_release: got done=%b lat=%0d px=%0d, want done=1 lat=2 px=1",
                        got, lat, pos_x);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blocked();
    test_cell_walk();
    test_wall();
    test_reverse();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
